// File: rtl/ext_bus_master.sv
// ext_bus_master
// Byte-serial external memory bus master. One CPU request at a time is
// taken over a valid/ready port. It is sent over an 8-bit bidirectional
// bus as address beats and then data beats, least significant byte first.
// Each beat uses a 4-phase handshake (hs_out / hs_in). A per-beat timeout
// is optional.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready is combinational)
//   req_write           1 = write, 0 = read
//   req_addr/wdata      request address / write data
//   req_done/error      end-of-transaction pulse / timeout qualifier
//   req_rdata           read data, held until the next read completes
//   bus_in/out/oe       8-bit bus input, output and output enable
//   hs_in/hs_out        asynchronous handshake in / handshake out
//   bus_rd/bus_wr       transaction type status while busy
//   busy                transaction in progress
module ext_bus_master #(
  parameter int ADDR_BYTES  = 2,
  parameter int DATA_BYTES  = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    req_ready,
  output logic                    req_done,
  output logic                    req_error,
  output logic [8*DATA_BYTES-1:0] req_rdata,
  input  logic [7:0]              bus_in,
  output logic [7:0]              bus_out,
  output logic [7:0]              bus_oe,
  input  logic                    hs_in,
  output logic                    hs_out,
  output logic                    bus_rd,
  output logic                    bus_wr,
  output logic                    busy
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam logic [1:0] A_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] D_LAST = 2'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    PH_WAIT_LOW = 1'b0,
    PH_DRIVE    = 1'b1
  } phase_t;

  state_t               state_r, state_n;
  phase_t               phase_r, phase_n;
  logic [1:0]           idx_r, idx_n;
  logic [CW-1:0]        cnt_r, cnt_n;
  logic [AW-1:0]        addr_r, addr_n;
  logic [DW-1:0]        wdata_r, wdata_n;
  logic                 write_r, write_n;
  logic [DW-1:0]        rbuf_r, rbuf_n, rbuf_merge_s;
  logic [DW-1:0]        rdata_r, rdata_n;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                 hs_s;
  logic                 done_n, error_n;
  logic                 drive_n;
  logic [7:0]           byte_n;
  logic                 hs_out_r, done_r, error_r, rd_r, wr_r, busy_r;
  logic [7:0]           bus_oe_r, bus_out_r;

  // Select byte i of a little-endian word.
  function automatic logic [7:0] pick_byte(input logic [31:0] v, input logic [1:0] i);
    return 8'(v >> {i, 3'b000});
  endfunction

  assign hs_s = sync_r[SYNC_STAGES-1];

  // Current read buffer with the bus byte merged into the active beat slot.
  assign rbuf_merge_s = DW'((32'(rbuf_r) & ~(32'h0000_00FF << {idx_r, 3'b000}))
                            | (32'(bus_in) << {idx_r, 3'b000}));

  assign req_ready = (state_r == ST_IDLE) && !rst;
  assign req_done  = done_r;
  assign req_error = error_r;
  assign req_rdata = rdata_r;
  assign bus_out   = bus_out_r;
  assign bus_oe    = bus_oe_r;
  assign hs_out    = hs_out_r;
  assign bus_rd    = rd_r;
  assign bus_wr    = wr_r;
  assign busy      = busy_r;

  // Next-state logic for the transaction FSM and beat sub-FSM.
  always_comb begin
    state_n = state_r;
    phase_n = phase_r;
    idx_n   = idx_r;
    cnt_n   = cnt_r;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    write_n = write_r;
    rbuf_n  = rbuf_r;
    rdata_n = rdata_r;
    done_n  = 1'b0;
    error_n = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Reset overrides this in the register process, so req_ready's
        // dependence on rst need not be repeated here.
        if (req_valid) begin
          addr_n  = req_addr;
          wdata_n = req_wdata;
          write_n = req_write;
          idx_n   = 2'd0;
          phase_n = PH_WAIT_LOW;
          state_n = ST_ADDR;
        end else begin
          phase_n = PH_WAIT_LOW;
        end
      end
      ST_ADDR, ST_DATA: begin
        case (phase_r)
          PH_WAIT_LOW: begin
            if (!hs_s) begin
              phase_n = PH_DRIVE;
              cnt_n   = '0;
            end else begin
              phase_n = PH_WAIT_LOW;
            end
          end
          PH_DRIVE: begin
            // A late acknowledge in the expiry cycle still wins.
            if (hs_s) begin
              phase_n = PH_WAIT_LOW;
              if (state_r == ST_ADDR) begin
                if (idx_r == A_LAST) begin
                  state_n = ST_DATA;
                  idx_n   = 2'd0;
                end else begin
                  idx_n = idx_r + 2'd1;
                end
              end else begin
                if (!write_r) begin
                  rbuf_n = rbuf_merge_s;
                end else begin
                  rbuf_n = rbuf_r;
                end
                if (idx_r == D_LAST) begin
                  state_n = ST_IDLE;
                  idx_n   = 2'd0;
                  done_n  = 1'b1;
                  if (!write_r) begin
                    rdata_n = rbuf_merge_s;
                  end else begin
                    rdata_n = rdata_r;
                  end
                end else begin
                  idx_n = idx_r + 2'd1;
                end
              end
            end else if ((TIMEOUT > 0) && (cnt_r == TO_LAST)) begin
              state_n = ST_IDLE;
              phase_n = PH_WAIT_LOW;
              idx_n   = 2'd0;
              done_n  = 1'b1;
              error_n = 1'b1;
            end else begin
              cnt_n = cnt_r + CW'(1);
            end
          end
          default: phase_n = PH_WAIT_LOW;
        endcase
      end
      default: begin
        state_n = ST_IDLE;
        phase_n = PH_WAIT_LOW;
      end
    endcase
  end

  // Bus drive for the cycle after this edge, derived from the next state so
  // that all bus outputs can be registered.
  always_comb begin
    drive_n = (state_n == ST_ADDR) || ((state_n == ST_DATA) && write_n);
    if (state_n == ST_ADDR) begin
      byte_n = pick_byte(32'(addr_n), idx_n);
    end else begin
      byte_n = pick_byte(32'(wdata_n), idx_n);
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      phase_r   <= PH_WAIT_LOW;
      idx_r     <= 2'd0;
      cnt_r     <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      write_r   <= 1'b0;
      rbuf_r    <= '0;
      rdata_r   <= '0;
      sync_r    <= '1;
      hs_out_r  <= 1'b0;
      bus_oe_r  <= 8'h00;
      bus_out_r <= 8'h00;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      phase_r   <= phase_n;
      idx_r     <= idx_n;
      cnt_r     <= cnt_n;
      addr_r    <= addr_n;
      wdata_r   <= wdata_n;
      write_r   <= write_n;
      rbuf_r    <= rbuf_n;
      rdata_r   <= rdata_n;
      sync_r    <= {sync_r[SYNC_STAGES-2:0], hs_in};
      hs_out_r  <= (state_n != ST_IDLE) && (phase_n == PH_DRIVE);
      bus_oe_r  <= drive_n ? 8'hFF : 8'h00;
      bus_out_r <= drive_n ? byte_n : 8'h00;
      done_r    <= done_n;
      error_r   <= error_n;
      rd_r      <= (state_n != ST_IDLE) && !write_n;
      wr_r      <= (state_n != ST_IDLE) && write_n;
      busy_r    <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ext_bus_master.sv
// Testbench for ext_bus_master. Instance A uses the default widths with no
// timeout. Instance B uses 3 address bytes, 2 data bytes and TIMEOUT=16.
// A small handshake responder per instance logs every beat as {oe, out}.
module tb_ext_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A signals
  logic        a_rst = 1'b1, a_valid = 1'b0, a_write = 1'b0;
  logic [15:0] a_addr = 16'h0;
  logic [7:0]  a_wdata = 8'h0;
  logic        a_ready, a_done, a_error, a_hs_out, a_bus_rd, a_bus_wr, a_busy;
  logic [7:0]  a_rdata, a_bus_out, a_bus_oe;
  logic [7:0]  a_bus_in = 8'h00;
  logic        a_hold = 1'b1, a_respond = 1'b1, a_bfm_hs = 1'b0, a_seen = 1'b0;
  wire         a_hs_in = a_hold | a_bfm_hs;
  logic [15:0] a_log [64];
  logic [7:0]  a_rsp [64];
  int          a_nb = 0;

  // Instance B signals
  logic        b_rst = 1'b1, b_valid = 1'b0, b_write = 1'b0;
  logic [23:0] b_addr = 24'h0;
  logic [15:0] b_wdata = 16'h0;
  logic        b_ready, b_done, b_error, b_hs_out, b_bus_rd, b_bus_wr, b_busy;
  logic [15:0] b_rdata;
  logic [7:0]  b_bus_out, b_bus_oe;
  logic [7:0]  b_bus_in = 8'h00;
  logic        b_respond = 1'b1, b_bfm_hs = 1'b0, b_seen = 1'b0;
  wire         b_hs_in = b_bfm_hs;
  logic [15:0] b_log [64];
  logic [7:0]  b_rsp [64];
  int          b_nb = 0;

  ext_bus_master #(.ADDR_BYTES(2), .DATA_BYTES(1), .SYNC_STAGES(2), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_ready(a_ready),
    .req_done(a_done), .req_error(a_error), .req_rdata(a_rdata),
    .bus_in(a_bus_in), .bus_out(a_bus_out), .bus_oe(a_bus_oe),
    .hs_in(a_hs_in), .hs_out(a_hs_out), .bus_rd(a_bus_rd), .bus_wr(a_bus_wr),
    .busy(a_busy)
  );

  ext_bus_master #(.ADDR_BYTES(3), .DATA_BYTES(2), .SYNC_STAGES(2), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(b_ready),
    .req_done(b_done), .req_error(b_error), .req_rdata(b_rdata),
    .bus_in(b_bus_in), .bus_out(b_bus_out), .bus_oe(b_bus_oe),
    .hs_in(b_hs_in), .hs_out(b_hs_out), .bus_rd(b_bus_rd), .bus_wr(b_bus_wr),
    .busy(b_busy)
  );

  // Responder A: log the beat when hs_out rises, answer, and release on hs_out fall.
  always @(negedge clk) begin
    if (a_hs_out && !a_seen) begin
      a_log[a_nb] <= {a_bus_oe, a_bus_out};
      a_bus_in    <= a_rsp[a_nb];
      a_nb        <= a_nb + 1;
      a_seen      <= 1'b1;
      a_bfm_hs    <= a_respond;
    end else if (!a_hs_out) begin
      a_seen   <= 1'b0;
      a_bfm_hs <= 1'b0;
    end
  end

  // Responder B: same behaviour as responder A.
  always @(negedge clk) begin
    if (b_hs_out && !b_seen) begin
      b_log[b_nb] <= {b_bus_oe, b_bus_out};
      b_bus_in    <= b_rsp[b_nb];
      b_nb        <= b_nb + 1;
      b_seen      <= 1'b1;
      b_bfm_hs    <= b_respond;
    end else if (!b_hs_out) begin
      b_seen   <= 1'b0;
      b_bfm_hs <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request, hold it until accepted, then drop req_valid.
  task automatic issue(input bit to_b, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd);
    int t;
    @(negedge clk);
    if (to_b) begin
      b_valid = 1'b1; b_write = wr; b_addr = addr[23:0]; b_wdata = wd[15:0];
    end else begin
      a_valid = 1'b1; a_write = wr; a_addr = addr[15:0]; a_wdata = wd[7:0];
    end
    t = 0;
    while (!(to_b ? b_ready : a_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_seen", {31'd0, t < 100}, 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_done(input bit to_b, input string tag);
    int c;
    c = 0;
    while (!(to_b ? b_done : a_done) && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done_seen"}, {31'd0, c < 400}, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rsp;
    logic [47:0] beats;   // {beat2, beat1, beat0}, each {oe, out}
    logic [7:0]  rdata;
  } a_vec_t;

  a_vec_t vecs [4];

  initial begin
    int base, t, k;
    logic any_high;
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t, k;
    logic any_high;
    logic [31:0] act_seq;

    vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 48'hFFA5_FF12_FF34, 8'h00};
    vecs[1] = '{1'b0, 16'h0001, 8'h00, 8'h5A, 48'h0000_FF00_FF01, 8'h5A};
    vecs[2] = '{1'b1, 16'hBEEF, 8'h3C, 8'h00, 48'hFF3C_FFBE_FFEF, 8'h5A};
    vecs[3] = '{1'b0, 16'h80FE, 8'h00, 8'hC7, 48'h0000_FF80_FFFE, 8'hC7};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_a_outs", {2'd0, a_hs_out, a_bus_oe, a_bus_out, a_done, a_error,
                       a_bus_rd, a_bus_wr, a_busy, a_rdata}, 32'd0);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_outs", {10'd0, b_hs_out, b_bus_oe, b_bus_out, b_done, b_error,
                       b_bus_rd, b_bus_wr, b_busy}, 32'd0);
    chk("rst_b_rdata", {16'd0, b_rdata}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // hs_in held high through reset release: no beat until it has been low
    base = a_nb;
    issue(1'b0, 1'b1, 32'h0F0F, 32'h01);
    any_high = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_high = any_high | a_hs_out;
    end
    chk("hold_hs_out_low", {31'd0, any_high}, 32'd0);
    a_hold = 1'b0;
    @(negedge clk);
    chk("hold_rise_1", {31'd0, a_hs_out}, 32'd0);
    @(negedge clk);
    chk("hold_rise_2", {31'd0, a_hs_out}, 32'd0);
    @(negedge clk);
    chk("hold_rise_3", {31'd0, a_hs_out}, 32'd1);
    wait_done(1'b0, "hold");
    chk("hold_beat0", {16'd0, a_log[base]}, 32'hFF0F);
    chk("hold_beat2", {16'd0, a_log[base+2]}, 32'hFF01);

    // Table of single transactions on instance A
    for (int i = 0; i < 4; i++) begin
      base = a_nb;
      a_rsp[base+2] = vecs[i].rsp;
      issue(1'b0, vecs[i].wr, {16'd0, vecs[i].addr}, {24'd0, vecs[i].wdata});
      wait_done(1'b0, "vec");
      chk("vec_error", {31'd0, a_error}, 32'd0);
      chk("vec_rdata", {24'd0, a_rdata}, {24'd0, vecs[i].rdata});
      for (int j = 0; j < 3; j++) begin
        chk("vec_beat", {16'd0, a_log[base+j]}, {16'd0, vecs[i].beats[16*j +: 16]});
      end
      @(negedge clk);
      chk("vec_done_pulse", {31'd0, a_done}, 32'd0);
      chk("vec_beat_count", a_nb - base, 32'd3);
    end

    // Back-to-back write then read with req_valid held
    base = a_nb;
    a_rsp[base+5] = 8'h96;
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 16'h00C3; a_wdata = 8'h77;
    @(negedge clk);   // accepted at the edge before this sample
    chk("b2b_wr_first", {30'd0, a_bus_wr, a_bus_rd}, 32'd2);
    a_write = 1'b0; a_addr = 16'h0055; a_wdata = 8'h00;
    t = 0;
    while (!a_done && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_first_done", {31'd0, t < 400}, 32'd1);
    chk("b2b_ready_at_done", {31'd0, a_ready}, 32'd1);
    chk("b2b_status_at_done", {30'd0, a_bus_wr, a_bus_rd}, 32'd0);
    @(negedge clk);
    chk("b2b_rd_second", {29'd0, a_busy, a_bus_wr, a_bus_rd}, 32'd5);
    a_valid = 1'b0;
    wait_done(1'b0, "b2b2");
    chk("b2b_rdata", {24'd0, a_rdata}, 32'h96);
    chk("b2b_wbeat", {16'd0, a_log[base+2]}, 32'hFF77);
    chk("b2b_rbeat0", {16'd0, a_log[base+3]}, 32'hFF55);
    chk("b2b_rbeat2", {16'd0, a_log[base+5]}, 32'h0000);

    // Reset pulsed during the second address beat
    base = a_nb;
    issue(1'b0, 1'b1, 32'h1234, 32'h99);
    t = 0;
    while (a_nb < base + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_second_beat", {31'd0, t < 200}, 32'd1);
    a_rst = 1'b1;
    #1;
    chk("mid_ready_in_rst", {31'd0, a_ready}, 32'd0);
    @(negedge clk);
    a_rst = 1'b0;
    chk("mid_after_rst", {21'd0, a_hs_out, a_bus_oe, a_busy, a_done}, 32'd0);
    any_high = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_high = any_high | a_done;
    end
    chk("mid_no_done", {31'd0, any_high}, 32'd0);
    base = a_nb;
    a_rsp[base+2] = 8'h3E;
    issue(1'b0, 1'b0, 32'h0001, 32'h0);
    wait_done(1'b0, "mid_read");
    chk("mid_read_err", {31'd0, a_error}, 32'd0);
    chk("mid_read_rdata", {24'd0, a_rdata}, 32'h3E);
    act_seq = {a_log[base+1], a_log[base]};
    chk("mid_read_abeats", act_seq, 32'hFF00_FF01);

    // Instance B: three address beats, two read data beats
    base = b_nb;
    b_rsp[base+3] = 8'h11;
    b_rsp[base+4] = 8'h22;
    issue(1'b1, 1'b0, 32'h000A_BCDE, 32'h0);
    wait_done(1'b1, "b_read");
    chk("b_read_err", {31'd0, b_error}, 32'd0);
    chk("b_read_rdata", {16'd0, b_rdata}, 32'h2211);
    chk("b_beats01", {b_log[base+1], b_log[base]}, 32'hFFBC_FFDE);
    chk("b_beats23", {b_log[base+3], b_log[base+2]}, 32'h0000_FF0A);
    chk("b_beat4", {16'd0, b_log[base+4]}, 32'h0000);

    // Instance B: first beat never acknowledged -> timeout
    b_respond = 1'b0;
    base = b_nb;
    issue(1'b1, 1'b0, 32'h0000_0102, 32'h0);
    t = 0;
    while (!b_hs_out && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("to_hs_rise", {31'd0, t < 50}, 32'd1);
    k = 0;
    while (!b_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("to_latency", k, 32'd16);
    chk("to_error", {31'd0, b_error}, 32'd1);
    chk("to_rdata_kept", {16'd0, b_rdata}, 32'h2211);
    @(negedge clk);
    chk("to_released", {23'd0, b_hs_out, b_bus_oe}, 32'd0);
    chk("to_idle", {30'd0, b_busy, b_done}, 32'd0);
    chk("to_beats", b_nb - base, 32'd1);
    b_respond = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ext_bus_master.md
# ext_bus_master

Parametrised byte-serial external memory bus master. It replaces the fixed 16-bit-address, 8-bit-data handshake engine that sits between the CPU core and the `uio` pins. Width is configurable in both address and data bytes. The asynchronous handshake input passes through a synchroniser, and a per-beat timeout aborts transactions with an error flag. The CPU core issues one request at a time through a valid/ready port; the block serialises it over an 8-bit bidirectional bus with a 4-phase handshake.

## Interface
Parameters:
- `ADDR_BYTES`, 2: address beats per transaction (1..4).
- `DATA_BYTES`, 1: data beats per transaction (1..4).
- `SYNC_STAGES`, 2: flops on the `hs_in` synchroniser (>=2).
- `TIMEOUT`, 0: maximum cycles `hs_out` may stay high waiting for `hs_in`. A value of 0 disables the timeout.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset. One clock; all state is reset synchronously.
- `req_valid` in 1: request present.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 8*ADDR_BYTES: address.
- `req_wdata` in 8*DATA_BYTES: write data.
- `req_ready` out 1: request accepted this cycle when high together with `req_valid`.
- `req_done` out 1: one-cycle pulse at transaction end.
- `req_error` out 1: qualifies `req_done`; the transaction timed out.
- `req_rdata` out 8*DATA_BYTES: read data, valid while `req_done` is high and held until the next read completes.
- `bus_in` in 8: bus input path.
- `bus_out` out 8: bus output path.
- `bus_oe` out 8: output enable, all ones or all zeros.
- `hs_in` in 1: asynchronous handshake from the external side.
- `hs_out` out 1: handshake to the external side.
- `bus_rd`, `bus_wr` out 1: transaction type status, high from acceptance to `req_done`.
- `busy` out 1: not in IDLE.

## Operation
- Synchroniser: `hs_in` passes through SYNC_STAGES flops, giving `hs_s`. On reset all flops load 1, so the block must see a real low before the first beat.
- Transaction FSM: IDLE → ADDR → DATA → IDLE.
  - `req_ready` = (state == IDLE) && !rst.
  - On accept, latch addr, wdata and type; beat index := 0; go to ADDR.
- Beat order:
  - ADDR sends ADDR_BYTES beats, least significant byte first.
  - DATA sends DATA_BYTES beats, LSB first.
  - Write: DATA beats drive `req_wdata` bytes.
  - Read: DATA beats tri-state the bus, and each beat captures `bus_in` into byte[index] of `req_rdata`.
- Beat sub-FSM:
  - WAIT_LOW: wait for `hs_s` == 0.
  - DRIVE: `hs_out` = 1, waiting for `hs_s` == 1.
  - In the cycle `hs_s` == 1 is seen: capture the read byte, drop `hs_out` next cycle, and advance the beat index. After the last DATA beat, pulse `req_done` and return to IDLE.
- Bus drive:
  - `bus_oe` = 8'hFF and `bus_out` = current byte throughout WAIT_LOW and DRIVE of ADDR beats and write DATA beats; otherwise `bus_oe` = 0.
  - `bus_out` = 0 when not driving.
  - `bus_out` is stable for at least one cycle before `hs_out` rises and until `hs_out` falls.
- Timeout (TIMEOUT > 0):
  - A counter clears on entering DRIVE and increments each DRIVE cycle.
  - When it reaches TIMEOUT without `hs_s` high: pulse `req_done` with `req_error` = 1, drop `hs_out` and `bus_oe` next cycle, return to IDLE, and leave `req_rdata` unchanged.
  - Counter width is $clog2(TIMEOUT+1).
- Simultaneous events:
  - `hs_s` high in the same cycle the timeout expires counts as success.
  - `req_valid` during a transaction is ignored because `req_ready` is 0.
- Reset mid-transaction: the next cycle shows `hs_out` = 0, `bus_oe` = 0, IDLE, and no `req_done`.

## Timing
- Reset values:
  - `hs_out`, `bus_oe`, `bus_out`, `req_done`, `req_error`, `bus_rd`, `bus_wr` and `busy` are all 0.
  - `req_ready` = 0 while `rst` is high.
  - `req_rdata` = 0.
- All outputs are registered except `req_ready`.
- The `hs_in` edge reaches `hs_s` SYNC_STAGES cycles later.
- `hs_out` rises no earlier than the cycle after WAIT_LOW observes `hs_s` == 0.
- `req_done` occurs one cycle after the final beat's `hs_s` high is observed.
- Back-to-back: a new request can be accepted in the cycle after `req_done`.
- External contract:
  - The external side holds `bus_in` stable from its `hs_in` rise until it observes `hs_out` fall.
  - It returns `hs_in` low before the next beat.

## Test plan
- Write, defaults: addr 0x1234, wdata 0xA5 → beats 0x34, 0x12, 0xA5 with `bus_oe` = FF each; one `req_done`, `req_error` = 0.
- Read, ADDR_BYTES=3, DATA_BYTES=2: addr 0x0ABCDE; the BFM returns 0x11 then 0x22 → beats 0xDE, 0xBC, 0x0A driven, then bus released; `req_rdata` = 0x2211.
- TIMEOUT=16: the BFM never raises `hs_in` on the first beat → `req_done` with `req_error` = 1 exactly 16 cycles after `hs_out` rises; the next cycle has `hs_out` = 0 and `bus_oe` = 0, and `req_rdata` is unchanged.
- `hs_in` held high at reset release plus a request → `hs_out` stays 0 until `hs_in` has been low for SYNC_STAGES cycles.
- `rst` pulsed during the second ADDR beat → next cycle IDLE, `hs_out` = 0, `bus_oe` = 0, no `req_done`; a following read of 0x0001 completes normally.
- Back-to-back write then read with `req_valid` held → the second is accepted the cycle after the first `req_done`; `bus_wr` then `bus_rd` toggle correctly.
